score_packer: RTL and testbench

Serial-to-parallel front end for the argmax output stage. Collects N output-neuron scores streamed one per accepted cycle, packs them into an N*DATA_WIDTH vector, and presents it to the argmax comparator with a single-cycle `load` strobe. Holds the vector stable until the comparator returns its valid pulse, then re-arms for the next frame. Sits between the final layer's score stream and the comparator's `data_in`/`load`/`valid_out` ports.

---
 rtl/score_packer_if.sv | 25 ++
 rtl/score_packer.sv | 76 +++++++
 tb/tb_score_packer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/score_packer_if.sv
// Score stream in, packed vector / load strobe out, comparator valid back.
// slave is the packer side; master is the side driving scores and the comparator.
interface score_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 10
);
    logic                    in_valid;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_last;
    logic                    in_ready;
    logic                    result_valid;
    logic [N*DATA_WIDTH-1:0] data_out;
    logic                    load;
    logic                    frame_err;

    modport slave (
        input  in_valid, in_data, in_last, result_valid,
        output in_ready, data_out, load, frame_err
    );

    modport master (
        output in_valid, in_data, in_last, result_valid,
        input  in_ready, data_out, load, frame_err
    );
endinterface

// File: rtl/score_packer.sv
// Packs N streamed scores into one vector, strobes the argmax comparator,
// and holds the vector until the comparator answers.
module score_packer #(
    parameter int DATA_WIDTH  = 8,
    parameter int N           = 10,
    parameter int INDEX_WIDTH = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    score_packer_if.slave bus
);
    typedef enum logic [1:0] {FILL, LOAD, WAIT_RES} state_t;

    state_t                             state_q, state_d;
    logic [INDEX_WIDTH-1:0]             idx_q, idx_d;
    logic [N-1:0][DATA_WIDTH-1:0]       data_q, data_d;
    logic                               load_q, load_d;
    logic                               err_q, err_d;
    logic                               last_slot;

    assign last_slot = (idx_q == INDEX_WIDTH'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        load_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    data_d[idx_q] = bus.in_data;
                    // Frame closes on the last slot or on in_last; exactly one of
                    // the two alone means the frame was malformed.
                    if (last_slot || bus.in_last) begin
                        state_d = LOAD;
                        load_d  = 1'b1;
                        err_d   = (last_slot != bus.in_last);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LOAD: state_d = WAIT_RES;
            WAIT_RES: begin
                if (bus.result_valid) begin
                    state_d = FILL;
                    idx_d   = '0;
                    data_d  = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign bus.in_ready  = (state_q == FILL);
    assign bus.data_out  = data_q;
    assign bus.load      = load_q;
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_score_packer.sv
// Directed and randomized frames against a slot-array model of the packer,
// with the comparator's valid pulse returned by the bench.
module tb_score_packer;
    localparam int DW = 8;
    localparam int N  = 10;
    localparam int VW = N * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    score_packer_if #(.DATA_WIDTH(DW), .N(N)) bus ();

    score_packer #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int sc[N];
    logic [VW-1:0] expv;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // First index holding the largest score, as the comparator reports it.
    function automatic int argmax(input logic [VW-1:0] v);
        int best = 0;
        for (int i = 1; i < N; i++)
            if (v[i*DW +: DW] > v[best*DW +: DW]) best = i;
        return best;
    endfunction

    task automatic run_frame(input int cnt, input bit last_on_final, input int bubble_pct,
                             input int rv_delay, input bit spurious, input int exp_idx);
        int i = 0;
        int guard = 0;
        bit exp_err;
        expv = '0;
        for (int k = 0; k < cnt; k++) expv[k*DW +: DW] = DW'(sc[k]);
        exp_err = !(cnt == N && last_on_final);

        while (i < cnt && guard < 1000) begin
            bus.in_valid     = ($urandom_range(99) >= bubble_pct);
            bus.in_data      = bus.in_valid ? DW'(sc[i]) : DW'($urandom);
            bus.in_last      = bus.in_valid ? (last_on_final && i == cnt - 1) : 1'($urandom);
            bus.result_valid = spurious ? 1'($urandom) : 1'b0;
            check("in_ready_fill", VW'(bus.in_ready), VW'(1));
            check("load_fill", VW'(bus.load), VW'(0));
            step();
            guard++;
            if (bus.in_valid) i++;
        end
        if (guard >= 1000) check("fill_timeout", VW'(1), VW'(0));

        check("load_pulse", VW'(bus.load), VW'(1));
        check("frame_err", VW'(bus.frame_err), VW'(exp_err));
        check("in_ready_load", VW'(bus.in_ready), VW'(0));
        check("data_load", bus.data_out, expv);
        if (exp_idx >= 0) check("argmax", VW'(argmax(bus.data_out)), VW'(exp_idx));

        bus.in_valid     = 1'b1;
        bus.in_data      = DW'($urandom);
        bus.in_last      = 1'b0;
        bus.result_valid = 1'b0;
        step();
        check("in_ready_wait", VW'(bus.in_ready), VW'(0));
        check("load_wait", VW'(bus.load), VW'(0));
        check("err_wait", VW'(bus.frame_err), VW'(0));
        check("data_wait", bus.data_out, expv);
        for (int d = 0; d < rv_delay; d++) begin
            bus.in_data = DW'($urandom);
            step();
            check("in_ready_hold", VW'(bus.in_ready), VW'(0));
            check("data_hold", bus.data_out, expv);
        end

        bus.result_valid = 1'b1;
        step();
        bus.result_valid = 1'b0;
        check("in_ready_rearm", VW'(bus.in_ready), VW'(1));
        check("data_clear", bus.data_out, VW'(0));
        check("load_rearm", VW'(bus.load), VW'(0));
    endtask

    initial begin
        int cnt;
        bit lst;
        int saved[N];

        bus.in_valid     = 1'b1;
        bus.in_data      = 8'hAA;
        bus.in_last      = 1'b0;
        bus.result_valid = 1'b0;
        step();
        step();
        check("rst_data", bus.data_out, VW'(0));
        check("rst_load", VW'(bus.load), VW'(0));
        check("rst_err", VW'(bus.frame_err), VW'(0));
        check("rst_in_ready", VW'(bus.in_ready), VW'(1));
        rst_n = 1'b1;

        // Full frame 1..10, then 10..1 back-to-back with in_valid held high.
        for (int k = 0; k < N; k++) sc[k] = k + 1;
        run_frame(N, 1'b1, 0, 0, 1'b0, 9);
        for (int k = 0; k < N; k++) sc[k] = N - k;
        run_frame(N, 1'b1, 0, 0, 1'b0, 0);

        // Short frame.
        sc[0] = 5; sc[1] = 9; sc[2] = 3; sc[3] = 7;
        run_frame(4, 1'b1, 0, 0, 1'b0, 1);

        // Missing last.
        for (int k = 0; k < N; k++) sc[k] = $urandom_range(255);
        run_frame(N, 1'b0, 0, 0, 1'b0, -1);

        // Stalls, delayed comparator, spurious result_valid in FILL; then same scores clean.
        for (int k = 0; k < N; k++) begin sc[k] = $urandom_range(255); saved[k] = sc[k]; end
        run_frame(N, 1'b1, 40, 6, 1'b1, -1);
        for (int k = 0; k < N; k++) sc[k] = saved[k];
        run_frame(N, 1'b1, 0, 0, 1'b0, -1);

        // Reset after 5 scores, with in_valid held high through reset.
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(200 + k);
            bus.in_last  = 1'b0;
            step();
        end
        #1 rst_n = 1'b0;
        #1;
        check("midrst_data", bus.data_out, VW'(0));
        check("midrst_load", VW'(bus.load), VW'(0));
        check("midrst_err", VW'(bus.frame_err), VW'(0));
        check("midrst_in_ready", VW'(bus.in_ready), VW'(1));
        step();
        check("midrst_no_xfer", bus.data_out, VW'(0));
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) sc[k] = 20 + 3 * k;
        run_frame(N, 1'b1, 0, 0, 1'b0, 9);

        // Randomized frames.
        for (int f = 0; f < 20; f++) begin
            cnt = $urandom_range(N, 2);
            lst = (cnt < N) ? 1'b1 : 1'($urandom);
            for (int k = 0; k < N; k++) sc[k] = $urandom_range(255);
            run_frame(cnt, lst, $urandom_range(50), $urandom_range(4), 1'($urandom), -1);
        end

        bus.in_valid = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
